pwm_multichannel_gen: RTL
=========================

// Module: pwm_multichannel_gen
// PURPOSE
//  Parametrised multi-channel PWM generator; successor to fixed 3 x 5 MHz PLL clocking of the PWM path.
//  Common prescaler derives a tick from refclk; each channel has programmable period, duty, phase.
//  Double-buffered (shadow/active) settings commit glitch-free at each channel's period boundary.
//  Sits between the Qsys register bridge (write port) and the motor/LED PWM pins.
// PARAMETERS
//  NUM_CH    3    number of PWM channels (1..16)
//  CNT_W     16   width of period/duty/phase values and per-channel counters
//  PRESCALE  10   refclk cycles per tick (>=1); 50 MHz / 10 = 5 MHz tick
//  CH_W      derived localparam = max(1, clog2(NUM_CH)); not overridable
// PORTS
//  refclk       in   1       single clock; all logic on rising edge
//  rst_n        in   1       synchronous, active-low reset
//  wr_en        in   1       write strobe, one refclk cycle per write
//  wr_ch        in   CH_W    target channel; wr_ch >= NUM_CH -> write ignored
//  wr_sel       in   2       0=period 1=duty 2=phase 3=reserved (ignored)
//  wr_data      in   CNT_W   value written to selected shadow register
//  commit       in   1       pulse: request shadow->active copy on all channels
//  ch_en        in   NUM_CH  per-channel run enable (level)
//  pwm_out      out  NUM_CH  registered PWM outputs
//  wrap_pulse   out  NUM_CH  1-cycle pulse when channel counter wraps to 0
//  upd_pending  out  NUM_CH  1 = commit requested, not yet applied on channel
// BEHAVIOUR
//  Reset (rst_n=0 at edge): prescaler, counters, shadow+active regs, pending = 0; all outputs 0.
//  Prescaler: pcnt 0..PRESCALE-1; tick=1 in the cycle pcnt==PRESCALE-1; PRESCALE=1 -> tick every cycle.
//  Shadow write: on wr_en, shadow[wr_ch][wr_sel] <= wr_data; no effect on active values or output.
//  Counter (per channel, active period P, duty D, phase F):
//   - runs only when ch_en=1 and P!=0; advances on tick only.
//   - on tick: cnt==P-1 -> cnt<=0, wrap_pulse=1 next cycle; else cnt<=cnt+1.
//   - ch_en 0->1 or commit applied: cnt <= (F>=P) ? 0 : F.
//   - ch_en=0 or P=0: cnt held at 0, no wraps.
//  Output: pwm_out[i] <= run & (cnt < D), registered: 1 cycle after counter value.
//   - D=0 -> constant 0; D>=P -> constant 1 (no glitch at wrap).
//   - ch_en falling: pwm_out low on the next edge.
//  Commit: commit=1 sets upd_pending for every channel.
//   - running channel: applied on the tick where cnt==P-1; active<=shadow, cnt<=new phase clamp, pending<=0.
//   - stopped channel (ch_en=0 or active P=0): applied on next edge.
//   - commit during pending: stays pending, no double apply; latest shadow values used at apply.
//   - wr_en and commit same cycle: write takes effect first; apply uses new shadow value.
//   - wr_en in the apply cycle: new value stays in shadow for next commit (apply reads old shadow).
//  Arithmetic: all unsigned CNT_W, no overflow possible (cnt < P <= 2^CNT_W-1).
//  Reset mid-period: immediate return to reset state; pending requests discarded.
// TESTING
//  1 Reset: hold rst_n=0 5 cycles with ch_en=all-1 -> pwm_out=0, wrap_pulse=0, upd_pending=0.
//  2 PRESCALE=10, ch0 P=4 D=1 F=0, commit, ch_en=1 -> pwm_out[0] high 10 / low 30 refclk, wrap every 40.
//  3 Mid-run ch0 D 1->3 + commit -> pending=1 until wrap; next period high 30 cycles; no runt pulse.
//  4 Phase: ch1 F=2, ch2 F=0 same P=4 D=2, enable together -> ch1 leads ch2 by 2 ticks (20 cycles).
//  5 Edge cases: D=0 -> constant 0; D=5 with P=4 -> constant 1; P=0 -> constant 0, no wrap_pulse.
//  6 Disable ch0 mid-high -> low next edge; wr_ch=NUM_CH write -> no shadow changes; reset during pending -> clears.

Source files
------------

// File: rtl/pwm_multichannel_gen.sv
// Multi-channel PWM generator: shared refclk prescaler tick, per-channel period/duty/phase
// held in shadow registers and copied to the active set at each channel's period boundary.
module pwm_multichannel_gen #(
    parameter  int NUM_CH   = 3,
    parameter  int CNT_W    = 16,
    parameter  int PRESCALE = 10,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [1:0]        wr_sel,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic              commit,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] wrap_pulse,
    output logic [NUM_CH-1:0] upd_pending
);
    localparam int               PC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [PC_W-1:0] pcnt_r;
    logic            tick_s;

    // A phase outside the period restarts the counter at zero.
    function automatic logic [CNT_W-1:0] start_count(input logic [CNT_W-1:0] phase,
                                                     input logic [CNT_W-1:0] period);
        if (phase >= period) begin
            start_count = '0;
        end else begin
            start_count = phase;
        end
    endfunction

    // Common prescaler producing one tick every PRESCALE refclk cycles.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            pcnt_r <= '0;
        end else if (pcnt_r == PC_LAST) begin
            pcnt_r <= '0;
        end else begin
            pcnt_r <= pcnt_r + PC_W'(1);
        end
    end

    assign tick_s = (pcnt_r == PC_LAST);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] sh_per_r, sh_duty_r, sh_phase_r;
        logic [CNT_W-1:0] act_per_r, act_duty_r, act_phase_r;
        logic [CNT_W-1:0] cnt_r;
        logic             en_prev_r, pend_r, pwm_r, wrap_r;
        logic             run_s, rise_s, last_s, wrap_evt_s, apply_s, wr_hit_s;

        // Per-channel run/boundary/apply decode.
        always_comb begin
            run_s      = ch_en[i] && (act_per_r != '0);
            rise_s     = ch_en[i] && !en_prev_r;
            last_s     = (cnt_r == (act_per_r - ONE));
            wrap_evt_s = run_s && !rise_s && tick_s && last_s;
            // Stopped channels take new settings at once; running ones only at the boundary.
            apply_s    = pend_r && (!run_s || wrap_evt_s);
            wr_hit_s   = wr_en && (wr_ch == CH_W'(i));
        end

        // Shadow register file written from the register bridge.
        always_ff @(posedge refclk) begin
            if (!rst_n) begin
                sh_per_r   <= '0;
                sh_duty_r  <= '0;
                sh_phase_r <= '0;
            end else if (wr_hit_s) begin
                case (wr_sel)
                    2'd0:    sh_per_r   <= wr_data;
                    2'd1:    sh_duty_r  <= wr_data;
                    2'd2:    sh_phase_r <= wr_data;
                    default: sh_per_r   <= sh_per_r;
                endcase
            end else begin
                sh_per_r <= sh_per_r;
            end
        end

        // Active settings, counter, pending flag and registered outputs.
        always_ff @(posedge refclk) begin
            if (!rst_n) begin
                act_per_r   <= '0;
                act_duty_r  <= '0;
                act_phase_r <= '0;
                cnt_r       <= '0;
                en_prev_r   <= 1'b0;
                pend_r      <= 1'b0;
                pwm_r       <= 1'b0;
                wrap_r      <= 1'b0;
            end else begin
                if (apply_s) begin
                    act_per_r   <= sh_per_r;
                    act_duty_r  <= sh_duty_r;
                    act_phase_r <= sh_phase_r;
                    cnt_r       <= start_count(sh_phase_r, sh_per_r);
                end else if (!run_s) begin
                    cnt_r <= '0;
                end else if (rise_s) begin
                    cnt_r <= start_count(act_phase_r, act_per_r);
                end else if (tick_s) begin
                    cnt_r <= last_s ? '0 : (cnt_r + ONE);
                end else begin
                    cnt_r <= cnt_r;
                end
                en_prev_r <= ch_en[i];
                pend_r    <= commit || (pend_r && !apply_s);
                // Suppressed on the enable edge so the stale stopped count never leaks out.
                pwm_r     <= run_s && !rise_s && (cnt_r < act_duty_r);
                wrap_r    <= wrap_evt_s;
            end
        end

        assign pwm_out[i]     = pwm_r;
        assign wrap_pulse[i]  = wrap_r;
        assign upd_pending[i] = pend_r;
    end

endmodule
